// File: rtl/fetch_req_stage_pkg.sv
// Shared types and constants for the pre-IF fetch request stage.
package fetch_req_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  localparam int unsigned BR_BUS_W     = 33;
  localparam int unsigned BR_TAKEN_BIT = 32;
  localparam int unsigned IF_BUS_W     = 65;
  localparam int unsigned ADEF_BIT     = 64;

  localparam logic [1:0]  SIZE_WORD = 2'b10;
  localparam logic [31:0] RESET_PC  = 32'h1c00_0000;

  function automatic logic [IF_BUS_W-1:0] pack_if_bus(input logic        adef,
                                                      input logic [31:0] inst,
                                                      input logic [31:0] pc);
    return {adef, inst, pc};
  endfunction

endpackage

// File: rtl/fetch_req_stage_if.sv
// Class-SRAM instruction bus between the fetch request stage and memory.
interface fetch_req_stage_if;

  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );

  modport slave (
    input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );

endinterface

// File: rtl/fetch_redirect_latch.sv
// Holds a pending fetch redirect; exception flush beats a same-cycle branch,
// and a newer redirect overwrites an older pending one.
module fetch_redirect_latch
  import fetch_req_stage_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                exec_flush,
  input  logic [31:0]         exec_pc,
  input  logic [BR_BUS_W-1:0] br_bus,
  input  logic                consume,
  output logic                redirect_now,
  output logic                sel_valid,
  output logic [31:0]         sel_pc
);

  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] target;

  assign redirect_now = exec_flush | br_bus[BR_TAKEN_BIT];
  assign target       = exec_flush ? exec_pc : br_bus[31:0];

  // A same-cycle redirect is visible to the consumer before it is registered.
  assign sel_valid = redirect_now | redirect_valid;
  assign sel_pc    = redirect_now ? target : redirect_pc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else if (consume) begin
      redirect_valid <= 1'b0;
    end else if (redirect_now) begin
      redirect_valid <= 1'b1;
      redirect_pc    <= target;
    end
  end

endmodule

// File: rtl/fetch_req_stage.sv
// Pre-IF stage: owns the fetch PC, issues one outstanding SRAM fetch at a time
// and hands {adef, inst, pc} bundles to IF.
module fetch_req_stage #(
  parameter logic [31:0] RESET_PC = fetch_req_stage_pkg::RESET_PC
) (
  input  logic                                    clk,
  input  logic                                    resetn,
  input  logic [fetch_req_stage_pkg::BR_BUS_W-1:0] br_bus,
  input  logic                                    exec_flush,
  input  logic [31:0]                             WB_pc_gen_exec,
  input  logic                                    IF_allowin,
  output logic                                    to_IF_valid,
  output logic [fetch_req_stage_pkg::IF_BUS_W-1:0] to_IF_bus,
  fetch_req_stage_if.master                       inst_bus
);

  import fetch_req_stage_pkg::*;

  fetch_state_e          state, state_nxt;
  logic [31:0]           fetch_pc, fetch_pc_nxt;
  logic                  discard, discard_nxt;
  logic [IF_BUS_W-1:0]   bundle, bundle_nxt;
  logic                  consume;
  logic                  redirect_now;
  logic                  sel_valid;
  logic [31:0]           sel_pc;
  logic [31:0]           req_addr;

  fetch_redirect_latch u_redirect (
    .clk          (clk),
    .resetn       (resetn),
    .exec_flush   (exec_flush),
    .exec_pc      (WB_pc_gen_exec),
    .br_bus       (br_bus),
    .consume      (consume),
    .redirect_now (redirect_now),
    .sel_valid    (sel_valid),
    .sel_pc       (sel_pc)
  );

  assign req_addr = sel_valid ? sel_pc : fetch_pc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      discard  <= 1'b0;
      bundle   <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      discard  <= discard_nxt;
      bundle   <= bundle_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    discard_nxt  = discard;
    bundle_nxt   = bundle;
    consume      = 1'b0;
    case (state)
      ST_IDLE: begin
        // IDLE lasts one cycle and always commits the chosen address.
        consume      = 1'b1;
        fetch_pc_nxt = req_addr;
        if (req_addr[1:0] != 2'b00) begin
          bundle_nxt = pack_if_bus(1'b1, 32'h0, req_addr);
          state_nxt  = ST_HOLD;
        end else begin
          state_nxt  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (redirect_now) discard_nxt = 1'b1;
        if (inst_bus.inst_addr_ok) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (inst_bus.inst_data_ok) begin
          if (discard || redirect_now) begin
            discard_nxt = 1'b0;
            state_nxt   = ST_IDLE;
          end else begin
            bundle_nxt  = pack_if_bus(1'b0, inst_bus.inst_rdata, fetch_pc);
            state_nxt   = ST_HOLD;
          end
        end else if (redirect_now) begin
          discard_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect_now) begin
          state_nxt = ST_IDLE;
        end else if (IF_allowin) begin
          fetch_pc_nxt = fetch_pc + 32'd4;
          state_nxt    = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign to_IF_valid = (state == ST_HOLD);
  assign to_IF_bus   = bundle;

  assign inst_bus.inst_req   = (state == ST_REQ);
  assign inst_bus.inst_addr  = fetch_pc;
  assign inst_bus.inst_wr    = 1'b0;
  assign inst_bus.inst_size  = SIZE_WORD;
  assign inst_bus.inst_wdata = '0;

endmodule

// File: tb/tb_fetch_req_stage.sv
// Directed bench for fetch_req_stage: sequential fetch, redirects, back-pressure,
// misaligned targets, PC wrap and reset during an outstanding fetch.
module tb_fetch_req_stage;

  localparam logic [31:0] MASK = 32'h5a5a_a5a5;

  logic        clk = 1'b0;
  logic        resetn;
  logic [32:0] br_bus;
  logic        exec_flush;
  logic [31:0] WB_pc_gen_exec;
  logic        IF_allowin;
  logic        to_IF_valid;
  logic [64:0] to_IF_bus;

  int tests  = 0;
  int failed = 0;

  fetch_req_stage_if bus ();

  fetch_req_stage #(.RESET_PC(32'h1c00_0000)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .br_bus         (br_bus),
    .exec_flush     (exec_flush),
    .WB_pc_gen_exec (WB_pc_gen_exec),
    .IF_allowin     (IF_allowin),
    .to_IF_valid    (to_IF_valid),
    .to_IF_bus      (to_IF_bus),
    .inst_bus       (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // Leaves the DUT in its first REQ cycle, sampled at a negedge.
  task automatic do_reset();
    resetn = 1'b0; br_bus = '0; exec_flush = 1'b0; WB_pc_gen_exec = '0;
    IF_allowin = 1'b1;
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_req(output bit ok);
    int n;
    n = 0;
    while (!bus.inst_req && n < 16) begin
      @(negedge clk);
      n++;
    end
    ok = bus.inst_req;
  endtask

  // Accepts the pending request after a_lat extra cycles, returns data next cycle.
  task automatic serve(input int a_lat, output logic [31:0] addr);
    repeat (a_lat) @(negedge clk);
    addr = bus.inst_addr;
    bus.inst_addr_ok = 1'b1;
    @(negedge clk);
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = addr ^ MASK;
    @(negedge clk);
    bus.inst_data_ok = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; br_bus = '0; exec_flush = 1'b0; WB_pc_gen_exec = '0;
    IF_allowin = 1'b1;
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;
    @(negedge clk);
    tests++; if (to_IF_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b expected 0", to_IF_valid); end
    tests++; if (bus.inst_req !== 1'b0) begin failed++; $display("FAIL reset_req: got %b expected 0", bus.inst_req); end
    tests++; if (to_IF_bus !== 65'h0) begin failed++; $display("FAIL reset_bus: got %h expected 0", to_IF_bus); end
    tests++; if (bus.inst_wr !== 1'b0) begin failed++; $display("FAIL const_wr: got %b expected 0", bus.inst_wr); end
    tests++; if (bus.inst_size !== 2'b10) begin failed++; $display("FAIL const_size: got %b expected 10", bus.inst_size); end
    tests++; if (bus.inst_wdata !== 32'h0) begin failed++; $display("FAIL const_wdata: got %h expected 0", bus.inst_wdata); end
  endtask

  task automatic test_sequential();
    logic [31:0] a, exp_a;
    bit ok;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      exp_a = 32'h1c00_0000 + 32'(4 * k);
      wait_req(ok);
      tests++; if (!ok) begin failed++; $display("FAIL seq_req_timeout: got none expected req %0d", k); end
      tests++; if (bus.inst_addr !== exp_a) begin failed++; $display("FAIL seq_addr: got %h expected %h", bus.inst_addr, exp_a); end
      serve(0, a);
      tests++; if (to_IF_valid !== 1'b1) begin failed++; $display("FAIL seq_valid: got %b expected 1", to_IF_valid); end
      tests++; if (to_IF_bus !== {1'b0, exp_a ^ MASK, exp_a}) begin failed++; $display("FAIL seq_bundle: got %h expected %h", to_IF_bus, {1'b0, exp_a ^ MASK, exp_a}); end
      @(negedge clk);
      tests++; if (bus.inst_req !== 1'b0 || to_IF_valid !== 1'b0) begin failed++; $display("FAIL seq_idle: got req=%b valid=%b expected 0/0", bus.inst_req, to_IF_valid); end
    end
  endtask

  task automatic test_redirect_in_req();
    logic [31:0] a;
    bit ok;
    do_reset();
    br_bus = 33'h1_1c00_0100;
    @(negedge clk);
    br_bus = '0;
    for (int i = 0; i < 3; i++) begin
      tests++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h1c00_0000) begin failed++; $display("FAIL req_stable: got req=%b addr=%h expected 1/1c000000", bus.inst_req, bus.inst_addr); end
      if (i == 2) bus.inst_addr_ok = 1'b1;
      @(negedge clk);
    end
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'hbad0_0bad;
    @(negedge clk);
    bus.inst_data_ok = 1'b0;
    tests++; if (to_IF_valid !== 1'b0) begin failed++; $display("FAIL stale_dropped: got %b expected 0", to_IF_valid); end
    wait_req(ok);
    tests++; if (!ok || bus.inst_addr !== 32'h1c00_0100) begin failed++; $display("FAIL redirect_addr: got %h expected 1c000100", bus.inst_addr); end
    serve(0, a);
    tests++; if (to_IF_valid !== 1'b1 || to_IF_bus !== {1'b0, 32'h1c00_0100 ^ MASK, 32'h1c00_0100}) begin failed++; $display("FAIL redirect_bundle: got %h expected %h", to_IF_bus, {1'b0, 32'h1c00_0100 ^ MASK, 32'h1c00_0100}); end
  endtask

  task automatic test_redirect_in_wait();
    logic [31:0] a;
    do_reset();
    bus.inst_addr_ok = 1'b1;
    @(negedge clk);
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'h1234_5678;
    br_bus = 33'h1_1c00_0300;
    @(negedge clk);
    bus.inst_data_ok = 1'b0;
    br_bus = '0;
    tests++; if (to_IF_valid !== 1'b0) begin failed++; $display("FAIL wait_same_cycle_drop: got %b expected 0", to_IF_valid); end
    @(negedge clk);
    tests++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h1c00_0300) begin failed++; $display("FAIL wait_redirect_addr: got req=%b addr=%h expected 1/1c000300", bus.inst_req, bus.inst_addr); end
    serve(0, a);
    tests++; if (to_IF_valid !== 1'b1 || to_IF_bus !== {1'b0, 32'h1c00_0300 ^ MASK, 32'h1c00_0300}) begin failed++; $display("FAIL wait_redirect_bundle: got %h expected %h", to_IF_bus, {1'b0, 32'h1c00_0300 ^ MASK, 32'h1c00_0300}); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    do_reset();
    IF_allowin = 1'b0;
    serve(0, a);
    for (int i = 0; i < 4; i++) begin
      tests++; if (to_IF_valid !== 1'b1 || bus.inst_req !== 1'b0 || to_IF_bus !== {1'b0, 32'h1c00_0000 ^ MASK, 32'h1c00_0000}) begin failed++; $display("FAIL hold_stable: got valid=%b req=%b bus=%h expected 1/0/%h", to_IF_valid, bus.inst_req, to_IF_bus, {1'b0, 32'h1c00_0000 ^ MASK, 32'h1c00_0000}); end
      @(negedge clk);
    end
    IF_allowin = 1'b1;
    @(negedge clk);
    tests++; if (to_IF_valid !== 1'b0 || bus.inst_req !== 1'b0) begin failed++; $display("FAIL handoff_idle: got valid=%b req=%b expected 0/0", to_IF_valid, bus.inst_req); end
    @(negedge clk);
    tests++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h1c00_0004) begin failed++; $display("FAIL resume_addr: got req=%b addr=%h expected 1/1c000004", bus.inst_req, bus.inst_addr); end
  endtask

  task automatic test_flush_priority();
    logic [31:0] a;
    do_reset();
    IF_allowin = 1'b0;
    serve(0, a);
    exec_flush = 1'b1; WB_pc_gen_exec = 32'h1c00_8000; br_bus = 33'h1_1c00_0200;
    @(negedge clk);
    exec_flush = 1'b0; br_bus = '0;
    tests++; if (to_IF_valid !== 1'b0) begin failed++; $display("FAIL hold_flush_drop: got %b expected 0", to_IF_valid); end
    @(negedge clk);
    tests++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h1c00_8000) begin failed++; $display("FAIL flush_priority: got req=%b addr=%h expected 1/1c008000", bus.inst_req, bus.inst_addr); end
    IF_allowin = 1'b1;
  endtask

  task automatic test_misaligned();
    logic [31:0] a;
    do_reset();
    IF_allowin = 1'b0;
    serve(0, a);
    br_bus = 33'h1_1c00_0102;
    @(negedge clk);
    br_bus = '0;
    tests++; if (bus.inst_req !== 1'b0) begin failed++; $display("FAIL adef_no_req_idle: got %b expected 0", bus.inst_req); end
    @(negedge clk);
    tests++; if (bus.inst_req !== 1'b0 || to_IF_valid !== 1'b1 || to_IF_bus !== 65'h1_0000_0000_1c00_0102) begin failed++; $display("FAIL adef_bundle: got req=%b valid=%b bus=%h expected 0/1/100000000_1c000102", bus.inst_req, to_IF_valid, to_IF_bus); end
    IF_allowin = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++; if (to_IF_valid !== 1'b1 || to_IF_bus !== 65'h1_0000_0000_1c00_0106) begin failed++; $display("FAIL adef_next: got valid=%b bus=%h expected 1/100000000_1c000106", to_IF_valid, to_IF_bus); end
  endtask

  task automatic test_wrap();
    logic [31:0] a;
    do_reset();
    IF_allowin = 1'b0;
    serve(0, a);
    br_bus = 33'h1_ffff_fffc;
    @(negedge clk);
    br_bus = '0;
    @(negedge clk);
    tests++; if (bus.inst_addr !== 32'hffff_fffc) begin failed++; $display("FAIL wrap_top_addr: got %h expected fffffffc", bus.inst_addr); end
    serve(0, a);
    tests++; if (to_IF_bus !== {1'b0, 32'hffff_fffc ^ MASK, 32'hffff_fffc}) begin failed++; $display("FAIL wrap_bundle: got %h expected %h", to_IF_bus, {1'b0, 32'hffff_fffc ^ MASK, 32'hffff_fffc}); end
    IF_allowin = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h0000_0000) begin failed++; $display("FAIL wrap_addr: got req=%b addr=%h expected 1/00000000", bus.inst_req, bus.inst_addr); end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] a;
    do_reset();
    bus.inst_addr_ok = 1'b1;
    @(negedge clk);
    bus.inst_addr_ok = 1'b0;
    resetn = 1'b0;
    #1;
    tests++; if (to_IF_valid !== 1'b0 || bus.inst_req !== 1'b0 || to_IF_bus !== 65'h0) begin failed++; $display("FAIL async_reset: got valid=%b req=%b bus=%h expected 0/0/0", to_IF_valid, bus.inst_req, to_IF_bus); end
    @(negedge clk);
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'hdead_beef;
    resetn = 1'b1;
    @(negedge clk);
    bus.inst_data_ok = 1'b0;
    tests++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h1c00_0000 || to_IF_valid !== 1'b0) begin failed++; $display("FAIL late_data_ignored: got req=%b addr=%h valid=%b expected 1/1c000000/0", bus.inst_req, bus.inst_addr, to_IF_valid); end
    serve(0, a);
    tests++; if (to_IF_valid !== 1'b1 || to_IF_bus !== {1'b0, 32'h1c00_0000 ^ MASK, 32'h1c00_0000}) begin failed++; $display("FAIL post_reset_bundle: got %h expected %h", to_IF_bus, {1'b0, 32'h1c00_0000 ^ MASK, 32'h1c00_0000}); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect_in_req();
    test_redirect_in_wait();
    test_backpressure();
    test_flush_priority();
    test_misaligned();
    test_wrap();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fetch_req_stage.md
Name: fetch_req_stage

Overview:
- Pre-IF stage, directly upstream of the IF stage.
- Owns the fetch PC and issues instruction fetches over a class-SRAM (req/addr_ok/data_ok) bus.
- Tracks the single outstanding fetch and discards stale responses after a redirect.
- Delivers an {adef, inst, pc} bundle to IF under a valid/allowin handshake.

Parameters:
- RESET_PC, 32'h1c000000, first fetch address after reset.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- br_bus  in  33  {taken[32], target[31:0]} from ID; sampled when taken=1
- exec_flush  in  1  exception/ertn redirect; has priority over br_bus
- WB_pc_gen_exec  in  32  redirect target when exec_flush=1
- IF_allowin  in  1  IF accepts a bundle this cycle
- to_IF_valid  out  1  bundle valid
- to_IF_bus  out  65  {adef[64], inst[63:32], pc[31:0]}
- inst_req  out  1  fetch request
- inst_wr  out  1  constant 0
- inst_size  out  2  constant 2'b10
- inst_addr  out  32  fetch address
- inst_wdata  out  32  constant 0
- inst_addr_ok  in  1  request accepted
- inst_data_ok  in  1  read data returned
- inst_rdata  in  32  read data

Behaviour:
- Reset (async, resetn=0): state=IDLE, fetch_pc=RESET_PC, redirect_valid=0, discard=0, to_IF_valid=0, inst_req=0, to_IF_bus=0.
- States:
  - IDLE: compute next request.
  - REQ: inst_req=1, waiting for addr_ok.
  - WAIT: waiting for data_ok.
  - HOLD: bundle buffered, to_IF_valid=1.
- Request address: redirect_valid ? redirect_pc : fetch_pc. When the request is issued, fetch_pc takes that value and redirect_valid clears.
- IDLE:
  - If the address is aligned, go to REQ.
  - If misaligned (addr[1:0]!=0), no bus request: build bundle {1, 32'h0, addr} and go to HOLD.
- REQ:
  - inst_req and inst_addr stay stable until addr_ok; a redirect never drops or changes an asserted request.
  - addr_ok=1 → WAIT.
- WAIT: data_ok=1 with discard=0 → capture inst_rdata into the bundle, HOLD.
- HOLD:
  - to_IF_valid=1.
  - On IF_allowin=1: fetch_pc += 4 (wraps modulo 2^32), state=IDLE.
  - A new request is issued no earlier than the cycle after hand-off.
- Exactly one outstanding transaction is allowed; inst_req=0 in WAIT and HOLD.
- Redirect event: exec_flush=1, or br_bus[32]=1. Target is WB_pc_gen_exec if exec_flush=1, else br_bus[31:0].
  - IDLE: store in redirect_pc/redirect_valid; used the same cycle.
  - REQ or WAIT: store redirect; set discard=1.
  - The in-flight response is dropped: data_ok with discard=1 clears discard and returns to IDLE, with no bundle produced.
  - If data_ok arrives in the same cycle as the redirect, that data is also dropped.
  - HOLD: drop the buffered bundle (to_IF_valid=0 next cycle), store redirect, go to IDLE.
  - Redirect while redirect_valid=1: the newer target overwrites the stored one; flush beats a same-cycle branch.
- Fetch latency: minimum 3 cycles from entering IDLE to to_IF_valid=1, assuming addr_ok in the first REQ cycle and data_ok the next cycle.
- Back-pressure: a bundle held in HOLD is unchanged while IF_allowin=0.

Decomposition:
- Shared package holds:
  - State encoding (IDLE/REQ/WAIT/HOLD).
  - Bus bit positions (BR_BUS_W=33, IF_BUS_W=65, ADEF_BIT=64).
  - Constants SIZE_WORD=2'b10 and RESET_PC.
- One natural sub-module: fetch_redirect_latch, holding redirect_valid/redirect_pc, flush-over-branch priority and overwrite.

Test Plan:
- Reset release, addr_ok and data_ok each 1 cycle after request, IF_allowin=1 → inst_addr sequence 0x1c000000, 0x1c000004, 0x1c000008; to_IF_bus pc/inst match, adef=0.
- addr_ok delayed 3 cycles, with br_bus=33'h1_1c000100 on the first REQ cycle → inst_addr stays 0x1c000000 until addr_ok; its data is discarded (no to_IF_valid); next request is 0x1c000100.
- IF_allowin=0 for 4 cycles while in HOLD → to_IF_bus stable, inst_req=0; fetch resumes the cycle after IF_allowin=1.
- exec_flush=1 with WB_pc_gen_exec=0x1c008000 in the same cycle as a taken branch to 0x1c000200 → next request 0x1c008000.
- Branch to 0x1c000102 → no inst_req; bundle {adef=1, inst=0, pc=0x1c000102} presented to IF.
- resetn deasserted during WAIT → outputs reset immediately; late data_ok is ignored; the first post-reset request is 0x1c000000.
